locked_reg_write_sequencer: RTL and testbench
=============================================

// Module: locked_reg_write_sequencer
// PURPOSE
// Upstream command stage for the 16-bit locked register. Accepts valid/ready requests from the bus
// side: data write, lock, and debug write. Drives the register's Data_in/write/Lock inputs.
// Keeps a shadow lock flag, applies trusted/debug_mode policy, and checks the lock key.
// Returns an ok/error response for each request. Goes to a sticky alarm after repeated bad keys.
// PARAMETERS
// DATA_W        16        width of request data and reg_data_in
// LOCK_KEY      16'hA5C3  key value a LOCK request must carry
// MAX_KEY_FAILS 3         bad-key count that triggers ALARM (range 1..7)
// PORTS
// Clk             in   1       clock, all state changes on rising edge
// resetn          in   1       asynchronous active-low reset
// req_valid       in   1       request present
// req_ready       out  1       sequencer can accept a request
// req_op          in   2       00=WRITE, 01=LOCK, 10=DBG_WRITE, 11=reserved
// req_data        in   DATA_W  write data, or key for LOCK
// trusted         in   1       requester is trusted; sampled in CHECK
// debug_mode      in   1       debug mode active; sampled in CHECK
// resp_valid      out  1       response present
// resp_ready      in   1       response consumer ready
// resp_err        out  1       1=request rejected; valid only while resp_valid
// reg_data_in     out  DATA_W  to register Data_in
// reg_write       out  1       to register write; single-cycle pulse
// reg_lock        out  1       to register Lock; single-cycle pulse
// locked          out  1       shadow of register lock state
// alarm           out  1       sticky bad-key alarm
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, req_ready=1. resp_valid, resp_err, reg_write, reg_lock,
//   locked and alarm are 0. reg_data_in=0. fail_cnt=0. Holds this way however far a request had got.
// - All outputs are registered. reg_data_in holds its last value between writes.
// - FSM states: IDLE, CHECK, RESP, ALARM. req_ready=1 only in IDLE.
// - IDLE: on edge k with req_valid=1, capture op and data, then go to CHECK.
// - CHECK: on edge k+1 decide the request, go to RESP, set resp_valid=1.
// - CHECK, WRITE: if locked=0, reg_data_in<=data, reg_write=1 for one cycle, resp_err=0.
//   Otherwise resp_err=1 and no pulse.
// - CHECK, LOCK with locked=1: resp_err=0, no pulse (idempotent).
// - CHECK, LOCK with data==LOCK_KEY: reg_lock=1 for one cycle, locked<=1, fail_cnt<=0, resp_err=0.
// - CHECK, LOCK with data!=LOCK_KEY: fail_cnt+1, resp_err=1.
//   If new fail_cnt==MAX_KEY_FAILS, go to ALARM instead of RESP; resp_valid=1, resp_err=1 still
//   returned once.
// - CHECK, DBG_WRITE: needs debug_mode=1, trusted=1 and locked=0; then same pulse as WRITE.
//   Otherwise resp_err=1. Debug never bypasses the lock.
// - CHECK, reserved op: resp_err=1, no pulse.
// - RESP: hold resp_valid and resp_err until resp_ready=1 on an edge, then go to IDLE.
//   If resp_ready=1 already at edge k+2, the response lasts one cycle.
// - ALARM: alarm=1 and req_ready=0 until reset. Pending error response completes through
//   resp_valid/resp_ready. locked is unchanged.
// - Latency: accept at edge k; reg_write/reg_lock high during cycle k+1..k+2; resp_valid from k+1.
// - Throughput: at most one request every 3 cycles.
// - Unlock: only reset clears locked. It clears the downstream register on the same reset.
// - req_valid outside IDLE: ignored, not captured. Requester must hold it until the handshake.
// - reg_write and reg_lock are never high in the same cycle.
// - fail_cnt saturates at MAX_KEY_FAILS.
// TESTING
// - After reset: WRITE 16'h1234, resp_ready=1 -> reg_write pulse 1 cycle, reg_data_in=1234,
//   resp_err=0.
// - LOCK key A5C3 -> reg_lock pulse, locked=1. Then WRITE 16'hBEEF -> resp_err=1, no reg_write,
//   reg_data_in stays 1234.
// - DBG_WRITE 16'h00FF: trusted=0 -> err. trusted=1, debug_mode=1, unlocked -> pulse.
//   Same after lock -> err.
// - Three LOCK 16'h0000 -> 3 errs, alarm=1 after third, req_ready=0, later requests ignored.
// - resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_err stable; no new request accepted.
// - resetn low during CHECK of a WRITE -> no reg_write pulse; all outputs 0; locked=0.

Source files
------------

// File: rtl/locked_reg_write_sequencer_if.sv
// Request/response bus between a requester (master) and the locked-register sequencer (slave).
interface locked_reg_write_sequencer_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_err
    );
endinterface

// File: rtl/locked_reg_write_sequencer.sv
// Command stage in front of the 16-bit locked register: applies lock/debug policy, checks the
// lock key, pulses the register's write/lock inputs and answers each request ok/error.
module locked_reg_write_sequencer #(
    parameter int unsigned       DATA_W        = 16,
    parameter logic [DATA_W-1:0] LOCK_KEY      = 16'hA5C3,
    parameter int unsigned       MAX_KEY_FAILS = 3
) (
    input  logic                               Clk,
    input  logic                               resetn,
    locked_reg_write_sequencer_if.slave        io_bus,
    input  logic                               i_trusted,
    input  logic                               i_debug_mode,
    output logic [DATA_W-1:0]                  o_reg_data_in,
    output logic                               o_reg_write,
    output logic                               o_reg_lock,
    output logic                               o_locked,
    output logic                               o_alarm
);

    typedef enum logic [1:0] {StIdle, StCheck, StResp, StAlarm} state_e;
    typedef enum logic [1:0] {OpWrite, OpLock, OpDbgWrite, OpRsvd} op_e;

    localparam logic [2:0] MaxFails = 3'(MAX_KEY_FAILS);

    state_e            r_state,       w_state_d;
    op_e               r_op,          w_op_d;
    logic [DATA_W-1:0] r_data,        w_data_d;
    logic              r_req_ready,   w_req_ready_d;
    logic              r_resp_valid,  w_resp_valid_d;
    logic              r_resp_err,    w_resp_err_d;
    logic [DATA_W-1:0] r_reg_data_in, w_reg_data_in_d;
    logic              r_reg_write,   w_reg_write_d;
    logic              r_reg_lock,    w_reg_lock_d;
    logic              r_locked,      w_locked_d;
    logic              r_alarm,       w_alarm_d;
    logic [2:0]        r_fail_cnt,    w_fail_cnt_d;
    logic [2:0]        w_fail_inc;

    assign w_fail_inc = (r_fail_cnt >= MaxFails) ? MaxFails : r_fail_cnt + 3'd1;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_op          <= OpWrite;
            r_data        <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_reg_data_in <= '0;
            r_reg_write   <= 1'b0;
            r_reg_lock    <= 1'b0;
            r_locked      <= 1'b0;
            r_alarm       <= 1'b0;
            r_fail_cnt    <= 3'd0;
        end else begin
            r_state       <= w_state_d;
            r_op          <= w_op_d;
            r_data        <= w_data_d;
            r_req_ready   <= w_req_ready_d;
            r_resp_valid  <= w_resp_valid_d;
            r_resp_err    <= w_resp_err_d;
            r_reg_data_in <= w_reg_data_in_d;
            r_reg_write   <= w_reg_write_d;
            r_reg_lock    <= w_reg_lock_d;
            r_locked      <= w_locked_d;
            r_alarm       <= w_alarm_d;
            r_fail_cnt    <= w_fail_cnt_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_op_d          = r_op;
        w_data_d        = r_data;
        w_req_ready_d   = r_req_ready;
        w_resp_valid_d  = r_resp_valid;
        w_resp_err_d    = r_resp_err;
        w_reg_data_in_d = r_reg_data_in;
        w_reg_write_d   = 1'b0;
        w_reg_lock_d    = 1'b0;
        w_locked_d      = r_locked;
        w_alarm_d       = r_alarm;
        w_fail_cnt_d    = r_fail_cnt;

        unique case (r_state)
            StIdle: begin
                if (io_bus.req_valid) begin
                    w_op_d        = op_e'(io_bus.req_op);
                    w_data_d      = io_bus.req_data;
                    w_req_ready_d = 1'b0;
                    w_state_d     = StCheck;
                end
            end
            StCheck: begin
                // Reject by default; each accepted case clears the error.
                w_resp_valid_d = 1'b1;
                w_resp_err_d   = 1'b1;
                w_state_d      = StResp;
                unique case (r_op)
                    OpWrite: begin
                        if (!r_locked) begin
                            w_resp_err_d    = 1'b0;
                            w_reg_write_d   = 1'b1;
                            w_reg_data_in_d = r_data;
                        end
                    end
                    OpLock: begin
                        if (r_locked) begin
                            w_resp_err_d = 1'b0;
                        end else if (r_data == LOCK_KEY) begin
                            w_resp_err_d = 1'b0;
                            w_reg_lock_d = 1'b1;
                            w_locked_d   = 1'b1;
                            w_fail_cnt_d = 3'd0;
                        end else begin
                            w_fail_cnt_d = w_fail_inc;
                            if (w_fail_inc == MaxFails) begin
                                w_state_d = StAlarm;
                                w_alarm_d = 1'b1;
                            end
                        end
                    end
                    OpDbgWrite: begin
                        // Debug access still honours the lock.
                        if (i_debug_mode && i_trusted && !r_locked) begin
                            w_resp_err_d    = 1'b0;
                            w_reg_write_d   = 1'b1;
                            w_reg_data_in_d = r_data;
                        end
                    end
                    OpRsvd: ;
                    default: ;
                endcase
            end
            StResp: begin
                if (io_bus.resp_ready) begin
                    w_resp_valid_d = 1'b0;
                    w_resp_err_d   = 1'b0;
                    w_req_ready_d  = 1'b1;
                    w_state_d      = StIdle;
                end
            end
            StAlarm: begin
                // Terminal until reset; only the final error response drains.
                if (r_resp_valid && io_bus.resp_ready) begin
                    w_resp_valid_d = 1'b0;
                    w_resp_err_d   = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign io_bus.req_ready  = r_req_ready;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_err   = r_resp_err;
    assign o_reg_data_in     = r_reg_data_in;
    assign o_reg_write       = r_reg_write;
    assign o_reg_lock        = r_reg_lock;
    assign o_locked          = r_locked;
    assign o_alarm           = r_alarm;

endmodule

// File: tb/tb_locked_reg_write_sequencer.sv
// Directed plus randomized bench for locked_reg_write_sequencer against a rule-level model.
module tb_locked_reg_write_sequencer;

    localparam logic [15:0] Key     = 16'hA5C3;
    localparam int          MaxFail = 3;

    logic        Clk;
    logic        resetn;
    logic        trusted;
    logic        debug_mode;
    logic [15:0] reg_data_in;
    logic        reg_write;
    logic        reg_lock;
    logic        locked;
    logic        alarm;

    int checks;
    int errors;

    // Reference model state
    logic        m_locked;
    logic        m_alarm;
    int          m_fail;
    logic [15:0] m_data;

    locked_reg_write_sequencer_if #(.DATA_W(16)) bus ();

    locked_reg_write_sequencer #(
        .DATA_W(16),
        .LOCK_KEY(Key),
        .MAX_KEY_FAILS(MaxFail)
    ) dut (
        .Clk(Clk),
        .resetn(resetn),
        .io_bus(bus),
        .i_trusted(trusted),
        .i_debug_mode(debug_mode),
        .o_reg_data_in(reg_data_in),
        .o_reg_write(reg_write),
        .o_reg_lock(reg_lock),
        .o_locked(locked),
        .o_alarm(alarm)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 0);
        chk({tag, "_pulses"}, 32'({reg_write, reg_lock}), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_alarm"}, 32'(alarm), 0);
        chk({tag, "_data"}, 32'(reg_data_in), 0);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_alarm  = 1'b0;
        m_fail   = 0;
        m_data   = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        #2;
        chk_reset_state("rst");
        model_reset();
        @(negedge Clk);
        resetn = 1'b1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] data, input logic tr,
                          input logic dbg, input int stall);
        logic e_err;
        logic e_w;
        logic e_l;
        if (m_alarm) begin
            bus.req_valid = 1'b1;
            bus.req_op    = op;
            bus.req_data  = data;
            repeat (3) begin
                @(posedge Clk);
                @(negedge Clk);
                chk("ign_ready", 32'(bus.req_ready), 0);
                chk("ign_resp", 32'(bus.resp_valid), 0);
                chk("ign_pulse", 32'({reg_write, reg_lock}), 0);
                chk("ign_alarm", 32'(alarm), 1);
                chk("ign_locked", 32'(locked), 32'(m_locked));
            end
            bus.req_valid = 1'b0;
            return;
        end
        chk("idle_ready", 32'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_data   = data;
        bus.resp_ready = 1'b0;
        trusted        = tr;
        debug_mode     = dbg;

        e_err = 1'b1;
        e_w   = 1'b0;
        e_l   = 1'b0;
        case (op)
            2'd0: if (!m_locked) begin e_err = 1'b0; e_w = 1'b1; m_data = data; end
            2'd1: begin
                if (m_locked) e_err = 1'b0;
                else if (data == Key) begin
                    e_err = 1'b0; e_l = 1'b1; m_locked = 1'b1; m_fail = 0;
                end else begin
                    m_fail = (m_fail + 1 > MaxFail) ? MaxFail : m_fail + 1;
                    if (m_fail == MaxFail) m_alarm = 1'b1;
                end
            end
            2'd2: if (dbg && tr && !m_locked) begin e_err = 1'b0; e_w = 1'b1; m_data = data; end
            default: ;
        endcase

        @(posedge Clk);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        chk("acc_ready", 32'(bus.req_ready), 0);
        chk("acc_resp", 32'(bus.resp_valid), 0);
        chk("acc_pulse", 32'({reg_write, reg_lock}), 0);

        @(posedge Clk);
        @(negedge Clk);
        chk("dec_resp_valid", 32'(bus.resp_valid), 1);
        chk("dec_resp_err", 32'(bus.resp_err), 32'(e_err));
        chk("dec_write", 32'(reg_write), 32'(e_w));
        chk("dec_lock", 32'(reg_lock), 32'(e_l));
        chk("dec_data", 32'(reg_data_in), 32'(m_data));
        chk("dec_locked", 32'(locked), 32'(m_locked));
        chk("dec_alarm", 32'(alarm), 32'(m_alarm));
        chk("dec_ready", 32'(bus.req_ready), 0);

        for (int i = 0; i < stall; i++) begin
            bus.resp_ready = 1'b0;
            bus.req_valid  = 1'b1;
            bus.req_op     = 2'($urandom_range(0, 3));
            bus.req_data   = 16'($urandom);
            @(posedge Clk);
            @(negedge Clk);
            chk("stall_valid", 32'(bus.resp_valid), 1);
            chk("stall_err", 32'(bus.resp_err), 32'(e_err));
            chk("stall_pulse", 32'({reg_write, reg_lock}), 0);
            chk("stall_ready", 32'(bus.req_ready), 0);
            chk("stall_data", 32'(reg_data_in), 32'(m_data));
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.resp_ready = 1'b0;
        chk("done_valid", 32'(bus.resp_valid), 0);
        chk("done_pulse", 32'({reg_write, reg_lock}), 0);
        chk("done_ready", 32'(bus.req_ready), 32'(!m_alarm));
        chk("done_data", 32'(reg_data_in), 32'(m_data));
    endtask

    // Reset lands between acceptance and the decision edge of an unlocked WRITE.
    task automatic reset_in_check(input logic [15:0] data);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_data  = data;
        @(posedge Clk);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        resetn        = 1'b0;
        #2;
        chk_reset_state("rchk");
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        chk_reset_state("rchk_hold");
        resetn = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk_reset_state("rchk_after");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        resetn         = 1'b0;
        trusted        = 1'b0;
        debug_mode     = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_data   = 16'h0;
        bus.resp_ready = 1'b0;
        model_reset();
        do_reset();

        do_req(2'd0, 16'h1234, 1'b0, 1'b0, 0);
        do_req(2'd2, 16'h00FF, 1'b0, 1'b1, 0);
        do_req(2'd2, 16'h00FF, 1'b1, 1'b1, 1);
        do_req(2'd3, 16'h5555, 1'b1, 1'b1, 0);
        do_req(2'd0, 16'h1234, 1'b0, 1'b0, 0);
        do_req(2'd1, Key, 1'b0, 1'b0, 0);
        do_req(2'd0, 16'hBEEF, 1'b1, 1'b1, 5);
        do_req(2'd2, 16'h00FF, 1'b1, 1'b1, 0);
        do_req(2'd1, 16'h0000, 1'b0, 1'b0, 0);
        reset_in_check(16'hCAFE);

        do_req(2'd1, 16'h0000, 1'b0, 1'b0, 0);
        do_req(2'd1, 16'h0000, 1'b0, 1'b0, 2);
        do_req(2'd1, 16'h0000, 1'b0, 1'b0, 0);
        do_req(2'd0, 16'h4321, 1'b1, 1'b1, 0);
        do_reset();

        do_req(2'd1, Key, 1'b0, 1'b0, 0);
        reset_in_check(16'h7777);
        do_req(2'd0, 16'h9999, 1'b0, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic [15:0] d;
            if (n % 16 == 15) do_reset();
            op = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            if (op == 2'd1 && $urandom_range(0, 1) == 1) d = Key;
            do_req(op, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
